// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shift-out on device clock falling edges, ack check.
// Define PS2_TX_RETRY_EN to retry once (same byte) after a NACK or timeout before reporting tx_error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_CPU,
  input  logic       resetp,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_AT     = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // NOTE: synchronizer resets to 1 (idle bus level) so leaving reset never fakes a falling edge.
  always_ff @(posedge CLK_CPU or posedge resetp) begin
    if (resetp) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  logic clk_s, data_s, fall, lines_idle;
  assign clk_s      = clk_sync[1];
  assign data_s     = data_sync[1];
  assign fall       = clk_prev & ~clk_s;
  assign lines_idle = clk_s & data_s;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    data_q;
  logic          ack_ok;
  logic          parity_bit;
  logic          watched, timed_out, nacked, fail;
`ifdef PS2_TX_RETRY_EN
  logic          retried;
`endif

  assign parity_bit = ~^data_q;
  assign watched    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  // A device edge in the same cycle as the last count wins over the timeout.
  assign timed_out  = watched && !fall && (cnt == TIMEOUT_LAST) &&
                      !((state == WAIT_IDLE) && lines_idle);
  assign nacked     = (state == WAIT_IDLE) && lines_idle && !ack_ok;
  assign fail       = timed_out || nacked;

  always_ff @(posedge CLK_CPU or posedge resetp) begin
    if (resetp) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      data_q      <= '0;
      ack_ok      <= 1'b0;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            data_q     <= tx_data;
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retried    <= 1'b0;
`endif
          end
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == START_AT) ps2_data_oe <= 1'b1;
          if (cnt == INHIBIT_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          cnt <= cnt + 1'b1;
          if (fall) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              ps2_data_oe <= ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~parity_bit;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          cnt <= cnt + 1'b1;
          if (fall) begin
            cnt    <= '0;
            ack_ok <= ~data_s;
            state  <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (lines_idle) begin
            if (ack_ok) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else if (fall) begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: these later non-blocking writes deliberately override the case branch above.
      if (fail) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        cnt         <= '0;
`ifdef PS2_TX_RETRY_EN
        if (!retried) begin
          retried    <= 1'b1;
          ps2_clk_oe <= 1'b1;
          state      <= INHIBIT;
        end else begin
          tx_error <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
`else
        tx_error <= 1'b1;
        tx_busy  <= 1'b0;
        state    <= IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-collector pad model plus a PS/2 device that clocks, samples and acks.
module tb_ps2_host_tx;

  localparam int INH   = 20;
  localparam int TO    = 200;
  localparam int HALF  = 20;
  localparam int LIMIT = 2000;

  logic       CLK_CPU  = 1'b0;
  logic       resetp   = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_CPU(CLK_CPU), .resetp(resetp), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  int tests = 0;
  int fails = 0;
  int err_total = 0;
  int done_total = 0;

  always @(negedge CLK_CPU) begin
    if (tx_done === 1'b1) done_total++;
    if (tx_error === 1'b1) err_total++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge CLK_CPU);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLK_CPU);
    tx_valid = 1'b0;
    check("accept_clk_oe", {31'b0, ps2_clk_oe}, 32'd1);
  endtask

  // Waits for the host clock-inhibit phase and returns its length and the data_oe history at its end.
  task automatic wait_request(output int inh_len, output logic d_last, output logic d_prev,
                              output logic ok);
    int g;
    g = 0;
    while (ps2_clk_oe !== 1'b1 && g < LIMIT) begin
      @(negedge CLK_CPU);
      g++;
    end
    inh_len = 0;
    d_last  = 1'b0;
    d_prev  = 1'b0;
    while (ps2_clk_oe === 1'b1 && g < LIMIT) begin
      d_prev = d_last;
      d_last = ps2_data_oe;
      inh_len++;
      @(negedge CLK_CPU);
      g++;
    end
    ok = (g < LIMIT);
  endtask

  // Device side: 10 clock pulses sampling on the rising edge, then the ack pulse (data low if ack).
  task automatic dev_xfer(input logic ack, input logic poke, output logic [10:0] bits,
                          output logic lat_a, output logic lat_b, output int inh_len,
                          output logic d_last, output logic d_prev, output logic ok);
    bits  = '0;
    lat_a = 1'b0;
    lat_b = 1'b0;
    wait_request(inh_len, d_last, d_prev, ok);
    if (ok) begin
      bits[0] = ps2_data_in;
      repeat (5) @(negedge CLK_CPU);
      for (int k = 1; k <= 10; k++) begin
        dev_clk = 1'b0;
        for (int c = 1; c <= HALF; c++) begin
          @(negedge CLK_CPU);
          if (k == 1 && c == 2) lat_a = ps2_data_oe;
          if (k == 1 && c == 3) lat_b = ps2_data_oe;
        end
        bits[k] = ps2_data_in;
        dev_clk = 1'b1;
        if (poke && k == 3) begin
          tx_data  = 8'h55;
          tx_valid = 1'b1;
        end
        for (int c = 1; c <= HALF; c++) begin
          @(negedge CLK_CPU);
          if (c == 1) tx_valid = 1'b0;
        end
      end
      if (ack) dev_data = 1'b0;
      repeat (5) @(negedge CLK_CPU);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK_CPU);
      dev_clk = 1'b1;
    end
  endtask

  task automatic wait_pulse(output logic got_done, output logic got_err);
    logic seen;
    seen = 1'b0;
    for (int c = 1; c <= LIMIT && !seen; c++) begin
      @(negedge CLK_CPU);
      if (c == 2) dev_data = 1'b1;
      if (tx_done === 1'b1 || tx_error === 1'b1) seen = 1'b1;
    end
    got_done = tx_done;
    got_err  = tx_error;
    dev_data = 1'b1;
  endtask

  initial begin
    logic [10:0] bits;
    logic        la, lb, dl, dp, ok, gd, ge;
    int          inh, n, attempts, err_snap, done_snap;

    repeat (3) @(negedge CLK_CPU);
    check("rst_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_done", {31'b0, tx_done}, 32'd0);
    check("rst_error", {31'b0, tx_error}, 32'd0);
    check("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    resetp = 1'b0;
    repeat (3) @(negedge CLK_CPU);

    // 0xED with ack: LSB-first 1,0,1,1,0,1,1,1, parity 1
    send_req(8'hED);
    check("ed_busy", {31'b0, tx_busy}, 32'd1);
    dev_xfer(1'b1, 1'b0, bits, la, lb, inh, dl, dp, ok);
    check("ed_req_ok", {31'b0, ok}, 32'd1);
    check("ed_inhibit_len", inh, INH);
    check("ed_start_last", {31'b0, dl}, 32'd1);
    check("ed_start_prev", {31'b0, dp}, 32'd0);
    check("ed_start_bit", {31'b0, bits[0]}, 32'd0);
    check("ed_data", {24'b0, bits[8:1]}, 32'h0000_00ED);
    check("ed_parity", {31'b0, bits[9]}, 32'd1);
    check("ed_stop", {31'b0, bits[10]}, 32'd1);
    check("ed_lat_2cyc", {31'b0, la}, 32'd1);
    check("ed_lat_3cyc", {31'b0, lb}, 32'd0);
    wait_pulse(gd, ge);
    check("ed_done", {31'b0, gd}, 32'd1);
    check("ed_no_err", {31'b0, ge}, 32'd0);
    check("ed_busy_fall", {31'b0, tx_busy}, 32'd0);
    check("ed_ready_pulse", {31'b0, tx_ready}, 32'd0);
    @(negedge CLK_CPU);
    check("ed_ready_after", {31'b0, tx_ready}, 32'd1);
    check("ed_done_1cyc", {31'b0, tx_done}, 32'd0);

    // 0x01: parity 0
    send_req(8'h01);
    dev_xfer(1'b1, 1'b0, bits, la, lb, inh, dl, dp, ok);
    check("x01_data", {24'b0, bits[8:1]}, 32'h0000_0001);
    check("x01_parity", {31'b0, bits[9]}, 32'd0);
    wait_pulse(gd, ge);
    check("x01_done", {31'b0, gd}, 32'd1);
    @(negedge CLK_CPU);

    // 0xFF: parity 1
    send_req(8'hFF);
    dev_xfer(1'b1, 1'b0, bits, la, lb, inh, dl, dp, ok);
    check("xff_data", {24'b0, bits[8:1]}, 32'h0000_00FF);
    check("xff_parity", {31'b0, bits[9]}, 32'd1);
    wait_pulse(gd, ge);
    check("xff_done", {31'b0, gd}, 32'd1);
    @(negedge CLK_CPU);

`ifdef PS2_TX_RETRY_EN
    attempts = 2;
`else
    attempts = 1;
`endif

    // NACK: device leaves data high in the ack slot
    done_snap = done_total;
    send_req(8'h5A);
    for (int a = 1; a <= attempts; a++) begin
      err_snap = err_total;
      dev_xfer(1'b0, 1'b0, bits, la, lb, inh, dl, dp, ok);
      check("nack_inhibit_len", inh, INH);
      check("nack_data", {24'b0, bits[8:1]}, 32'h0000_005A);
      check("nack_no_early_err", err_total, err_snap);
    end
    wait_pulse(gd, ge);
    check("nack_error", {31'b0, ge}, 32'd1);
    check("nack_no_done", {31'b0, gd}, 32'd0);
    repeat (3) @(negedge CLK_CPU);
    check("nack_done_total", done_total, done_snap);

    // Timeout: device never clocks after the inhibit phase
    send_req(8'h12);
    for (int a = 1; a <= attempts; a++) begin
      wait_request(inh, dl, dp, ok);
      check("to_req_ok", {31'b0, ok}, 32'd1);
      n = 0;
      while (!(tx_error === 1'b1 || ps2_clk_oe === 1'b1) && n < LIMIT) begin
        @(negedge CLK_CPU);
        n++;
      end
      check("to_cycles", n, TO);
      check("to_error", {31'b0, tx_error}, (a == attempts) ? 32'd1 : 32'd0);
      check("to_data_oe", {31'b0, ps2_data_oe}, 32'd0);
      if (a == attempts) check("to_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
    end
    repeat (3) @(negedge CLK_CPU);

    // Reset mid-byte after falling edge 5 (bit 4 of 0xA5 is 0, so data is being pulled low)
    send_req(8'hA5);
    wait_request(inh, dl, dp, ok);
    repeat (5) @(negedge CLK_CPU);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK_CPU);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge CLK_CPU);
    end
    dev_clk = 1'b0;
    repeat (HALF) @(negedge CLK_CPU);
    check("mid_data_oe_before", {31'b0, ps2_data_oe}, 32'd1);
    #2 resetp = 1'b1;
    #1;
    check("mid_rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
    check("mid_rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    check("mid_rst_ready", {31'b0, tx_ready}, 32'd1);
    check("mid_rst_busy", {31'b0, tx_busy}, 32'd0);
    dev_clk = 1'b1;
    repeat (2) @(negedge CLK_CPU);
    resetp = 1'b0;
    repeat (5) @(negedge CLK_CPU);

    // 0xF4 after the reset: parity 0
    send_req(8'hF4);
    dev_xfer(1'b1, 1'b0, bits, la, lb, inh, dl, dp, ok);
    check("f4_data", {24'b0, bits[8:1]}, 32'h0000_00F4);
    check("f4_parity", {31'b0, bits[9]}, 32'd0);
    wait_pulse(gd, ge);
    check("f4_done", {31'b0, gd}, 32'd1);
    @(negedge CLK_CPU);

    // 0x55 request pulsed during a 0xED transfer must be ignored
    send_req(8'hED);
    dev_xfer(1'b1, 1'b1, bits, la, lb, inh, dl, dp, ok);
    check("poke_data", {24'b0, bits[8:1]}, 32'h0000_00ED);
    check("poke_parity", {31'b0, bits[9]}, 32'd1);
    wait_pulse(gd, ge);
    check("poke_done", {31'b0, gd}, 32'd1);
    repeat (5) @(negedge CLK_CPU);
    check("poke_no_restart", {31'b0, ps2_clk_oe}, 32'd0);
    check("poke_ready", {31'b0, tx_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
